// File: rtl/load_sequencer.sv
// Multi-channel load sequencer: arms channels on i_start rising edges and grants them round-robin
// to run an enable / gap / re-enable pulse sequence, gated by the CPU run signal.
module load_sequencer #(
  parameter int NCH   = 4,
  parameter int GAP_W = 4,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   i_start,
  input  logic             i_cpu_reset,
  input  logic [GAP_W-1:0] i_gap,
  output logic [NCH-1:0]   o_enable,
  output logic [NCH-1:0]   o_re_enable,
  output logic             o_busy,
  output logic [CH_W-1:0]  o_grant_id,
  output logic [NCH-1:0]   o_done,
  output logic             o_abort
);

  typedef enum logic [1:0] {IDLE, ENA, GAP, REEN} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   start_q;
  logic             hist_valid_q;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic [NCH-1:0]   enable_q, enable_d;
  logic [NCH-1:0]   re_enable_q, re_enable_d;
  logic             busy_q, busy_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [NCH-1:0]   done_q, done_d;
  logic             abort_q, abort_d;

  logic [NCH-1:0]   start_rise;
  logic             pick_found;
  logic [CH_W-1:0]  pick_ch;
  logic [NCH-1:0]   pick_oh;
  logic [NCH-1:0]   grant_oh;

  // The first cycle after reset only samples i_start, so a level already high is not an edge.
  assign start_rise = i_start & ~start_q & {NCH{hist_valid_q}};
  assign pick_oh    = NCH'(1) << pick_ch;
  assign grant_oh   = NCH'(1) << grant_q;

  // Round-robin search starting one past the last granted channel.
  always_comb begin : arbiter
    logic [CH_W:0] idx;
    idx        = '0;
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, last_grant_q} + (CH_W+1)'(i + 1);
      if (idx >= (CH_W+1)'(NCH)) idx = idx - (CH_W+1)'(NCH);
      if (!pick_found && pending_q[idx[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_ch    = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    enable_d     = '0;
    re_enable_d  = '0;
    done_d       = '0;
    abort_d      = 1'b0;
    busy_d       = busy_q;
    grant_d      = grant_q;

    case (state_q)
      IDLE: begin
        // Holding off while o_done/o_abort is high guarantees an idle cycle between sequences.
        if (i_cpu_reset && pick_found && (done_q == '0) && !abort_q) begin
          pending_d = pending_q & ~pick_oh;
          gap_cnt_d = i_gap;
          enable_d  = pick_oh;
          busy_d    = 1'b1;
          grant_d   = pick_ch;
          state_d   = ENA;
        end
      end
      ENA, GAP: begin
        if (!i_cpu_reset) begin
          busy_d       = 1'b0;
          abort_d      = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if ((state_q == ENA && gap_cnt_q == '0) ||
                     (state_q == GAP && gap_cnt_q == GAP_W'(1))) begin
          re_enable_d = grant_oh;
          state_d     = REEN;
        end else if (state_q == ENA) begin
          state_d = GAP;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      REEN: begin
        busy_d       = 1'b0;
        done_d       = grant_oh;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A new edge wins over a same-cycle grant clear; a low run gate wipes everything.
    pending_d = pending_d | start_rise;
    if (!i_cpu_reset) pending_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      start_q      <= '0;
      hist_valid_q <= 1'b0;
      gap_cnt_q    <= '0;
      last_grant_q <= CH_W'(NCH - 1);
      enable_q     <= '0;
      re_enable_q  <= '0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      start_q      <= i_start;
      hist_valid_q <= 1'b1;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      enable_q     <= enable_d;
      re_enable_q  <= re_enable_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign o_enable    = enable_q;
  assign o_re_enable = re_enable_q;
  assign o_busy      = busy_q;
  assign o_grant_id  = grant_q;
  assign o_done      = done_q;
  assign o_abort     = abort_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed self-checking bench for load_sequencer: timing of each pulse sequence,
// round-robin order, abort handling and reset behaviour, cycle by cycle.
module tb_load_sequencer;

  localparam int NCH   = 4;
  localparam int GAP_W = 4;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   i_start;
  logic             i_cpu_reset;
  logic [GAP_W-1:0] i_gap;
  logic [NCH-1:0]   o_enable;
  logic [NCH-1:0]   o_re_enable;
  logic             o_busy;
  logic [CH_W-1:0]  o_grant_id;
  logic [NCH-1:0]   o_done;
  logic             o_abort;

  int checks   = 0;
  int failures = 0;

  load_sequencer #(.NCH(NCH), .GAP_W(GAP_W), .CH_W(CH_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_cpu_reset (i_cpu_reset),
    .i_gap       (i_gap),
    .o_enable    (o_enable),
    .o_re_enable (o_re_enable),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id),
    .o_done      (o_done),
    .o_abort     (o_abort)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pk(input logic [3:0] en, input logic [3:0] re,
                                     input logic [3:0] dn, input logic busy, input logic abrt);
    return {en, re, dn, busy, abrt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] start, input logic cpu, input logic [3:0] gap);
    i_start     = start;
    i_cpu_reset = cpu;
    i_gap       = gap;
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] expected);
    logic [13:0] observed;
    observed = {o_enable, o_re_enable, o_done, o_busy, o_abort};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed{en,re,done,busy,abort}=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkGrant(input string tag, input logic [CH_W-1:0] expected);
    checks++;
    assert (o_grant_id === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed grant=%0d expected=%0d", tag, o_grant_id, expected);
    end
  endtask

  localparam logic [13:0] IDLE_P = 14'b0;
  localparam logic [13:0] BUSY_P = 14'b00000000000010;

  initial begin
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 4'd1);
    #12;
    checkOutput("reset_outputs", IDLE_P);
    checkGrant("reset_grant", 2'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("idle_after_reset", IDLE_P);

    // gap=1 on channel 2
    applyStimulus(4'b0100, 1'b1, 4'd1);
    tick(); checkOutput("g1_pending", IDLE_P);
    tick(); checkOutput("g1_enable", pk(4'b0100, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("g1_grant", 2'd2);
    tick(); checkOutput("g1_idle", BUSY_P);
    tick(); checkOutput("g1_reen", pk(4'b0, 4'b0100, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("g1_done", pk(4'b0, 4'b0, 4'b0100, 1'b0, 1'b0));
    applyStimulus(4'b0000, 1'b1, 4'd0);
    tick(); checkOutput("g1_after", IDLE_P);

    // gap=0 on channel 0
    applyStimulus(4'b0001, 1'b1, 4'd0);
    tick(); checkOutput("g0_pending", IDLE_P);
    tick(); checkOutput("g0_enable", pk(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("g0_grant", 2'd0);
    tick(); checkOutput("g0_reen", pk(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("g0_done", pk(4'b0, 4'b0, 4'b0001, 1'b0, 1'b0));
    applyStimulus(4'b0000, 1'b1, 4'd15);
    tick(); checkOutput("g0_after", IDLE_P);

    // gap=15 on channel 1
    applyStimulus(4'b0010, 1'b1, 4'd15);
    tick(); checkOutput("g15_pending", IDLE_P);
    tick(); checkOutput("g15_enable", pk(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("g15_grant", 2'd1);
    for (int i = 0; i < 15; i++) begin
      tick(); checkOutput($sformatf("g15_idle%0d", i), BUSY_P);
    end
    tick(); checkOutput("g15_reen", pk(4'b0, 4'b0010, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("g15_done", pk(4'b0, 4'b0, 4'b0010, 1'b0, 1'b0));
    applyStimulus(4'b0000, 1'b1, 4'd0);

    // fresh reset so channel 0 has first priority
    tick();
    rst = 1'b0;
    #1 checkOutput("reset2_outputs", IDLE_P);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // simultaneous edges on 0,1,3 then a re-arm of channel 0
    applyStimulus(4'b1011, 1'b1, 4'd0);
    tick(); checkOutput("rr_pending", IDLE_P);
    tick(); checkOutput("rr_en0", pk(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rr_grant0", 2'd0);
    tick(); checkOutput("rr_re0", pk(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("rr_done0", pk(4'b0, 4'b0, 4'b0001, 1'b0, 1'b0));
    tick(); checkOutput("rr_gap0", IDLE_P);
    tick(); checkOutput("rr_en1", pk(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rr_grant1", 2'd1);
    applyStimulus(4'b1010, 1'b1, 4'd0);
    tick(); checkOutput("rr_re1", pk(4'b0, 4'b0010, 4'b0, 1'b1, 1'b0));
    applyStimulus(4'b1011, 1'b1, 4'd0);
    tick(); checkOutput("rr_done1", pk(4'b0, 4'b0, 4'b0010, 1'b0, 1'b0));
    tick(); checkOutput("rr_gap1", IDLE_P);
    tick(); checkOutput("rr_en3", pk(4'b1000, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rr_grant3", 2'd3);
    tick(); checkOutput("rr_re3", pk(4'b0, 4'b1000, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("rr_done3", pk(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0));
    tick(); checkOutput("rr_gap3", IDLE_P);
    tick(); checkOutput("rr_en0b", pk(4'b0001, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rr_grant0b", 2'd0);
    tick(); checkOutput("rr_re0b", pk(4'b0, 4'b0001, 4'b0, 1'b1, 1'b0));
    tick(); checkOutput("rr_done0b", pk(4'b0, 4'b0, 4'b0001, 1'b0, 1'b0));

    // abort during GAP
    applyStimulus(4'b0000, 1'b1, 4'd3);
    tick(); checkOutput("ab_idle", IDLE_P);
    applyStimulus(4'b0100, 1'b1, 4'd3);
    tick(); checkOutput("ab_pending", IDLE_P);
    tick(); checkOutput("ab_enable", pk(4'b0100, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("ab_grant", 2'd2);
    tick(); checkOutput("ab_gap", BUSY_P);
    applyStimulus(4'b0100, 1'b0, 4'd3);
    tick(); checkOutput("ab_abort", pk(4'b0, 4'b0, 4'b0, 1'b0, 1'b1));
    tick(); checkOutput("ab_after", IDLE_P);
    checkGrant("ab_grant_hold", 2'd2);

    // edge while run gate is low is discarded
    applyStimulus(4'b0000, 1'b0, 4'd0);
    tick();
    applyStimulus(4'b0001, 1'b0, 4'd0);
    tick();
    tick(); checkOutput("gated_low", IDLE_P);
    applyStimulus(4'b0001, 1'b1, 4'd0);
    tick(); checkOutput("gated_1", IDLE_P);
    tick(); checkOutput("gated_2", IDLE_P);
    tick(); checkOutput("gated_3", IDLE_P);

    // run gate dropped during REEN still completes
    applyStimulus(4'b0000, 1'b1, 4'd0);
    tick();
    applyStimulus(4'b0010, 1'b1, 4'd0);
    tick(); checkOutput("rn_pending", IDLE_P);
    tick(); checkOutput("rn_enable", pk(4'b0010, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rn_grant", 2'd1);
    tick(); checkOutput("rn_reen", pk(4'b0, 4'b0010, 4'b0, 1'b1, 1'b0));
    applyStimulus(4'b0010, 1'b0, 4'd0);
    tick(); checkOutput("rn_done", pk(4'b0, 4'b0, 4'b0010, 1'b0, 1'b0));
    tick(); checkOutput("rn_after", IDLE_P);

    // reset asserted during ENA with i_start held high
    applyStimulus(4'b0000, 1'b1, 4'd2);
    tick();
    applyStimulus(4'b1000, 1'b1, 4'd2);
    tick(); checkOutput("rs_pending", IDLE_P);
    tick(); checkOutput("rs_enable", pk(4'b1000, 4'b0, 4'b0, 1'b1, 1'b0));
    checkGrant("rs_grant", 2'd3);
    #2 rst = 1'b0;
    #1 checkOutput("rs_async_clear", IDLE_P);
    checkGrant("rs_async_grant", 2'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); checkOutput($sformatf("rs_held%0d", i), IDLE_P);
    end
    checkGrant("rs_final_grant", 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
